// File: rtl/comparator_serial.sv
`default_nettype none
// ============================================================================
// Module      : comparator_serial
// Description : Multi-cycle magnitude comparator. Walks two WIDTH-bit
//               operands DIGIT bits per clock from the MSB down and stops at
//               the first differing digit. Signed or unsigned per operation,
//               behind a start/busy/done handshake. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             E,
    output logic             G,
    output logic             L
);

    localparam int c_ndig = WIDTH / DIGIT;
    localparam int c_idxw = (c_ndig > 1) ? $clog2(c_ndig) : 1;
    localparam logic [c_idxw-1:0] c_idx_last = c_idxw'(c_ndig - 1);
    localparam logic [c_idxw-1:0] c_idx_one  = c_idxw'(1);
    localparam logic [c_idxw-1:0] c_idx_zero = '0;

    // Reject parameter combinations that cannot be split into whole digits.
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $error("comparator_serial: DIGIT must be >= 1 and divide WIDTH");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("comparator_serial: WIDTH must be >= 2");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_a_q;
    logic [WIDTH-1:0]    r_b_q;
    logic [c_idxw-1:0]   r_idx;
    logic                r_busy;
    logic                r_done;
    logic                r_e;
    logic                r_g;
    logic                r_l;

    logic [WIDTH-1:0]    w_a_map;
    logic [WIDTH-1:0]    w_b_map;
    logic [DIGIT-1:0]    w_a_dig;
    logic [DIGIT-1:0]    w_b_dig;
    logic                w_gt;
    logic                w_lt;

    // Offset-binary mapping: flipping the sign bit makes an unsigned compare
    // order two's-complement values correctly.
    assign w_a_map = {A[WIDTH-1] ^ signed_mode, A[WIDTH-2:0]};
    assign w_b_map = {B[WIDTH-1] ^ signed_mode, B[WIDTH-2:0]};

    // Current digit of each latched operand; only DIGIT bits of compare logic.
    assign w_a_dig = r_a_q[int'(r_idx) * DIGIT +: DIGIT];
    assign w_b_dig = r_b_q[int'(r_idx) * DIGIT +: DIGIT];
    assign w_gt    = (w_a_dig > w_b_dig);
    assign w_lt    = (w_a_dig < w_b_dig);

    // Control FSM: latch operands on start, then scan digits MSB-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_q   <= '0;
            r_b_q   <= '0;
            r_idx   <= c_idx_zero;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_e     <= 1'b0;
            r_g     <= 1'b0;
            r_l     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_q   <= w_a_map;
                        r_b_q   <= w_b_map;
                        r_idx   <= c_idx_last;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_gt) begin
                        r_e     <= 1'b0;
                        r_g     <= 1'b1;
                        r_l     <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_lt) begin
                        r_e     <= 1'b0;
                        r_g     <= 1'b0;
                        r_l     <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_idx == c_idx_zero) begin
                        r_e     <= 1'b1;
                        r_g     <= 1'b0;
                        r_l     <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx   <= r_idx - c_idx_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign E    = r_e;
    assign G    = r_g;
    assign L    = r_l;

endmodule
`default_nettype wire

// File: tb/tb_comparator_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_comparator_serial
// Description : Scoreboard bench for comparator_serial (WIDTH=8, DIGIT=2).
//               Stimulus pushes hand-computed results; a negedge monitor pops
//               and checks flags, latency and busy duration on every done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator_serial;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;

    typedef struct {
        logic e;
        logic g;
        logic l;
        int   k;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             smode = 1'b0;
    logic             busy;
    logic             done;
    logic             e_out;
    logic             g_out;
    logic             l_out;

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   busy_cnt = 0;
    exp_t exp_q[$];
    int   acc_q[$];

    comparator_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (a_in),
        .B           (b_in),
        .signed_mode (smode),
        .busy        (busy),
        .done        (done),
        .E           (e_out),
        .G           (g_out),
        .L           (l_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every done pops one expectation and checks it.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no done at t=%0t", $time);
            end else begin
                exp_t x;
                int   acc;
                x   = exp_q.pop_front();
                acc = acc_q.pop_front();
                chk("result_EGL", {29'd0, e_out, g_out, l_out}, {29'd0, x.e, x.g, x.l});
                chk("latency_k", cyc - acc, x.k);
                chk("busy_cycles", busy_cnt, x.k);
                chk("busy_at_done", int'(busy), 0);
            end
            busy_cnt = 0;
        end else if (rst) begin
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end
    end

    // Called at posedge+2; presents a request and records its accepting edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic e, input logic g, input logic l, input int k);
        exp_t x;
        x.e = e; x.g = g; x.l = l; x.k = k;
        a_in  = a;
        b_in  = b;
        smode = s;
        start = 1'b1;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        start = 1'b0;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        smode = 1'($urandom);
    endtask

    // Returns at posedge+2 of the done cycle, or flags a timeout.
    task automatic wait_done(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #2;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", max_cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #2;
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        chk("reset_state", {27'd0, busy, done, e_out, g_out, l_out}, 0);
        idle(1);

        // Unsigned 0xB7 vs 0x37: top digit 10 > 00.
        launch(8'hB7, 8'h37, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        wait_done(8);
        idle(1);
        // Signed -73 vs 55.
        launch(8'hB7, 8'h37, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        wait_done(8);
        idle(1);
        // Equal operands take every digit.
        launch(8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        wait_done(8);
        idle(1);
        // Differ only in the last digit.
        launch(8'h5A, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        wait_done(8);
        idle(1);
        // -128 vs 127 signed, 128 vs 127 unsigned.
        launch(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        wait_done(8);
        idle(1);
        launch(8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        wait_done(8);
        idle(1);

        // Start while busy is ignored; start in the done cycle is accepted.
        launch(8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        @(posedge clk);
        #2;
        a_in = 8'h00; b_in = 8'hFF; smode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(8);
        launch(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        wait_done(8);
        idle(1);

        // A new start leaves the previous result (L) visible while running.
        launch(8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        @(posedge clk);
        #2;
        chk("hold_during_run", {29'd0, e_out, g_out, l_out}, 1);
        wait_done(8);
        idle(1);

        // Abort in the second RUN cycle of an equal compare.
        launch(8'h66, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        chk("abort_state", {27'd0, busy, done, e_out, g_out, l_out}, 0);
        idle(6);
        chk("abort_no_done_busy", int'(busy), 0);

        // Normal completion after the abort.
        launch(8'hB7, 8'h37, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        wait_done(8);
        idle(3);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/comparator_serial.md
# comparator_serial

Parametrised, multi-cycle magnitude comparator that succeeds the fixed 4-bit combinational comparator. It compares two WIDTH-bit operands DIGIT bits per clock, starting at the MSB, and stops as soon as a digit differs. Signed or unsigned interpretation is selectable per operation. It sits behind a start/busy/done handshake so that wide comparisons close timing without a long combinational chain.

## Interface
- WIDTH, 8: operand width in bits, ≥ 2.
- DIGIT, 2: bits compared per cycle; must divide WIDTH (elaboration error otherwise); NDIG = WIDTH/DIGIT.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- A  in  WIDTH  operand A, sampled on the accepting edge.
- B  in  WIDTH  operand B, sampled on the accepting edge.
- signed_mode  in  1  1 = two's complement, 0 = unsigned; sampled with A/B.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; E/G/L are valid from this cycle.
- E  out  1  A == B.
- G  out  1  A > B.
- L  out  1  A < B.

## Operation
- FSM states IDLE and RUN; registers a_q, b_q, idx (clog2(NDIG) bits).
- IDLE with start=1: latch A, B and signed_mode. If signed, invert the MSB of both latched operands (offset-binary mapping), so an unsigned compare then gives the signed order. Set idx=NDIG-1 and go to RUN; busy=1.
- RUN: compare digit idx of a_q against digit idx of b_q, unsigned.
  - a digit > b digit: G=1, E=L=0, done=1, go to IDLE.
  - a digit < b digit: L=1, E=G=0, done=1, go to IDLE.
  - equal and idx==0: E=1, G=L=0, done=1, go to IDLE.
  - equal and idx>0: idx decrements, stay in RUN.
- Exactly one of E/G/L is 1 after the first done. All three hold their values until the next done; a new start does not clear them.
- start while busy=1 is ignored. A, B and signed_mode are don't-care outside the accepting edge.
- Reset values: state IDLE, busy=0, done=0, E=G=L=0, idx=0, a_q=b_q=0.
- rst in any state aborts the operation. No done is produced, and outputs return to reset values on that edge.
- rst has priority over start on the same edge.

## Timing
- Edge t accepts start; busy=1 from after edge t.
- The digit at idx=NDIG-1 is compared at edge t+1. A decision at the k-th RUN edge (k=1..NDIG) drives done=1, busy=0 and the result after edge t+k.
- Latency from start to done: min 1+1 = 2 cycles, max NDIG+1 cycles (equal operands always take the maximum).
- done is high exactly one cycle. A start asserted in the done cycle is accepted (state is IDLE), so back-to-back operations issue every k+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, DIGIT=2, unsigned: A=0xB7, B=0x37 → G=1 with done 2 cycles after start, E=L=0.
- Same operands, signed_mode=1 (−73 vs 55) → L=1 with done 2 cycles after start.
- A=B=0x5A, unsigned → E=1 with done 5 cycles after start; busy high for 4 cycles.
- A=0x5A, B=0x5B → L=1 with done 5 cycles after start. Then A=0x80, B=0x7F signed → L=1; unsigned → G=1.
- start pulsed again while busy with A=0x00, B=0xFF → ignored, first result unchanged. Then start in the done cycle → accepted, and the new result appears at the next done.
- rst asserted in the second RUN cycle of an A=B compare → busy=0, E=G=L=0 next cycle, no done pulse. A subsequent start completes normally.
